axis_result_packer: RTL

- TX-side output packer for the DeiT accelerator; the FPGA->DMA end of the result stream.
- Accepts one PPU result row per handshake: 16 x int8, 128 bits.
- Buffers rows in a small FIFO and serializes each row into two 64-bit AXI-Stream beats toward the DMA.
- Asserts TLAST on the final beat of an M-row output tile, then pulses done.

---
 rtl/axis_result_packer.sv | 98 +++++++++
 1 files changed

// File: rtl/axis_result_packer.sv
// axis_result_packer: buffers 128-bit PPU result rows and streams each as two 64-bit AXI-Stream beats, TLAST on the tile's final beat.
// Optional: define AXIS_PACKER_STALL_CNT_EN to add the o_stall_cycles backpressure counter.
module axis_result_packer #(
  parameter int ROW_W = 128,
  parameter int DATA_W = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int M_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [M_W-1:0]    i_row_count,
  input  logic [ROW_W-1:0]  i_row_data,
  input  logic              i_row_valid,
  output logic              o_row_ready,
  output logic [DATA_W-1:0] axis_out_tdata,
  output logic              axis_out_tvalid,
  input  logic              axis_out_tready,
  output logic              axis_out_tlast,
  output logic              o_busy,
  output logic              o_done
`ifdef AXIS_PACKER_STALL_CNT_EN
  , output logic [31:0]     o_stall_cycles
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [M_W-1:0] count, rows_in, rows_out;
  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] fill;
  logic [ROW_W-1:0] out_row;
  logic tvalid, phase;
  logic start_ok, fifo_full, fifo_empty, push, pop, hs, last_beat;
  assign start_ok = state == IDLE && i_start;
  assign fifo_full = fill == (AW+1)'(FIFO_DEPTH);
  assign fifo_empty = fill == '0;
  assign o_row_ready = state == RUN && !fifo_full && rows_in < count;
  assign push = i_row_valid && o_row_ready;
  assign hs = tvalid && axis_out_tready;
  assign last_beat = phase && rows_out == count - M_W'(1);
  // Reload on an empty register or on the second half's handshake, so rows stream without a bubble
  assign pop = state == RUN && !fifo_empty && (!tvalid || (hs && phase));
  assign axis_out_tvalid = tvalid;
  assign axis_out_tdata = phase ? out_row[ROW_W-1:DATA_W] : out_row[DATA_W-1:0];
  assign axis_out_tlast = tvalid && last_beat;
  assign o_busy = state == RUN;
  assign o_done = state == DONE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_next;
  always_comb begin
    state_next = state;
    if (state == IDLE && i_start) state_next = i_row_count != '0 ? RUN : DONE;
    else if (state == RUN && hs && axis_out_tlast) state_next = DONE;
    else if (state == DONE) state_next = IDLE;
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= i_row_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rows_in <= '0;
      rows_out <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      out_row <= '0;
      tvalid <= 1'b0;
      phase <= 1'b0;
    end else begin
      if (start_ok) begin
        count <= i_row_count;
        rows_in <= '0;
        rows_out <= '0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rows_in <= rows_in + M_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
      if (hs && phase) rows_out <= rows_out + M_W'(1);
      if (pop) begin
        out_row <= mem[rd_ptr];
        tvalid <= 1'b1;
        phase <= 1'b0;
      end else if (hs) begin
        tvalid <= !phase;
        phase <= !phase;
      end
    end
  end
`ifdef AXIS_PACKER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) o_stall_cycles <= '0;
    else if (state == RUN && tvalid && !axis_out_tready && o_stall_cycles != '1) o_stall_cycles <= o_stall_cycles + 32'd1;
  end
`endif
endmodule
